// File: rtl/dso_spi_host_if.sv
// Command/read-back channel of the DSO SPI host: one command in, read bytes out.
// master = command issuer, slave = the SPI host block.
interface dso_spi_host_if #(
    parameter int LEN_W = 12
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_read;
    logic [7:0]       cmd_opcode;
    logic [31:0]      cmd_wdata;
    logic [LEN_W-1:0] cmd_len;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             rd_last;

    modport master (
        output cmd_valid, cmd_read, cmd_opcode, cmd_wdata, cmd_len,
        input  cmd_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_opcode, cmd_wdata, cmd_len,
        output cmd_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/dso_spi_host.sv
// SPI mode-0 master for the DSO board MCU link: register writes and buffer reads,
// plus the trigger_mcu pulse generator and the ready_mcu synchroniser.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// LEAD  | ncs low, first MOSI bit driven, D cycles before first SCK rise
// SHIFT | SCK toggling every D cycles, MOSI on falls, MISO sampled on rises
// LAG   | ncs still low for D cycles after the last SCK fall
// GAP   | ncs high for D cycles before accepting the next command
module dso_spi_host #(
    parameter int CLK_DIV     = 4,
    parameter int LEN_W       = 12,
    parameter int TRIG_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    dso_spi_host_if.slave cmd,
    output logic          busy,
    output logic          sck_spi,
    output logic          mosi_spi,
    output logic          ncs_spi,
    input  logic          miso_spi,
    input  logic          trig_req,
    output logic          trigger_mcu,
    input  logic          ready_mcu,
    output logic          data_avail,
    output logic          data_avail_rise
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_LAG   = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [38:0]      tx_sr;
    logic [6:0]       rx_sr;
    logic [2:0]       bit_cnt;
    logic [LEN_W:0]   byte_rem;
    logic             op_phase;
    logic             is_read;
    logic             sample_due;
    logic             rd_valid_q;
    logic             rd_last_q;
    logic [7:0]       rd_data_q;

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign cmd.rd_valid  = rd_valid_q;
    assign cmd.rd_last   = rd_last_q;
    assign cmd.rd_data   = rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            byte_rem   <= '0;
            op_phase   <= 1'b0;
            is_read    <= 1'b0;
            sample_due <= 1'b0;
            sck_spi    <= 1'b0;
            mosi_spi   <= 1'b0;
            ncs_spi    <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            sample_due <= 1'b0;

            // MISO is taken at the end of the first SCK-high cycle, so the
            // completed byte is presented the cycle after the rising edge.
            if (sample_due) begin
                rx_sr <= {rx_sr[5:0], miso_spi};
                if (bit_cnt == 3'd7 && is_read && !op_phase) begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= {rx_sr, miso_spi};
                    rd_last_q  <= (byte_rem == '0);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        state    <= ST_LEAD;
                        ncs_spi  <= 1'b0;
                        div_cnt  <= DIV_LOAD;
                        mosi_spi <= cmd.cmd_opcode[7];
                        tx_sr    <= {cmd.cmd_opcode[6:0],
                                     cmd.cmd_read ? 32'd0 : cmd.cmd_wdata};
                        is_read  <= cmd.cmd_read;
                        byte_rem <= cmd.cmd_read ? (LEN_W+1)'(cmd.cmd_len)
                                                 : (LEN_W+1)'(4);
                        bit_cnt  <= '0;
                        op_phase <= 1'b1;
                    end
                end
                ST_LEAD: begin
                    if (div_cnt == '0) begin
                        state      <= ST_SHIFT;
                        sck_spi    <= 1'b1;
                        sample_due <= 1'b1;
                        div_cnt    <= DIV_LOAD;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LOAD;
                        if (!sck_spi) begin
                            sck_spi    <= 1'b1;
                            sample_due <= 1'b1;
                        end else begin
                            sck_spi  <= 1'b0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            mosi_spi <= tx_sr[38];
                            tx_sr    <= {tx_sr[37:0], 1'b0};
                            if (bit_cnt == 3'd7) begin
                                op_phase <= 1'b0;
                                if (byte_rem == '0) begin
                                    state    <= ST_LAG;
                                    mosi_spi <= 1'b0;
                                end else begin
                                    byte_rem <= byte_rem - 1'b1;
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_LAG: begin
                    if (div_cnt == '0) begin
                        state   <= ST_GAP;
                        ncs_spi <= 1'b1;
                        div_cnt <= DIV_LOAD;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (div_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Trigger pulse: retrigger simply reloads the down-counter.
    logic [TRIG_W-1:0] trig_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_cnt <= '0;
        end else if (trig_req) begin
            trig_cnt <= TRIG_W'(TRIG_CYCLES);
        end else if (trig_cnt != '0) begin
            trig_cnt <= trig_cnt - 1'b1;
        end
    end

    assign trigger_mcu = (trig_cnt != '0);

    logic sync_q1;
    logic sync_q2;
    logic avail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1         <= 1'b0;
            sync_q2         <= 1'b0;
            avail_q         <= 1'b0;
            data_avail_rise <= 1'b0;
        end else begin
            sync_q1         <= ready_mcu;
            sync_q2         <= sync_q1;
            avail_q         <= sync_q2;
            data_avail_rise <= sync_q2 & ~avail_q;
        end
    end

    assign data_avail = sync_q2;

endmodule

// File: tb/tb_dso_spi_host.sv
// Bench for dso_spi_host: vector table, hand sequences for reset/hold/trigger,
// and randomized frames and trigger/sync traffic checked against a timing model.
module tb_dso_spi_host;

    localparam int D     = 4;
    localparam int LEN_W = 12;
    localparam int TRIG  = 16;

    logic clk = 1'b0;
    logic rst;
    logic busy, sck_spi, mosi_spi, ncs_spi, miso_spi;
    logic trig_req, trigger_mcu, ready_mcu, data_avail, data_avail_rise;

    dso_spi_host_if #(.LEN_W(LEN_W)) bus ();

    dso_spi_host #(.CLK_DIV(D), .LEN_W(LEN_W), .TRIG_CYCLES(TRIG)) dut (
        .clk(clk), .rst(rst), .cmd(bus.slave), .busy(busy),
        .sck_spi(sck_spi), .mosi_spi(mosi_spi), .ncs_spi(ncs_spi), .miso_spi(miso_spi),
        .trig_req(trig_req), .trigger_mcu(trigger_mcu), .ready_mcu(ready_mcu),
        .data_avail(data_avail), .data_avail_rise(data_avail_rise)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // SPI slave model: byte-level view of mode 0.
    logic [7:0] slv_q[$];
    logic [7:0] mosi_q[$];
    int         slv_byte, slv_bit, ncs_fall_cnt = 0;
    logic [7:0] slv_tx, slv_rx;
    logic       prev_ncs = 1'b1, prev_sck = 1'b0;

    always @(ncs_spi or sck_spi) begin
        if (ncs_spi === 1'b1) begin
            miso_spi = 1'b0;
        end else if (prev_ncs) begin
            ncs_fall_cnt++;
            slv_byte = 0; slv_bit = 0; slv_tx = 8'hA5;
            miso_spi = slv_tx[7];
        end else if (sck_spi && !prev_sck) begin
            slv_rx = {slv_rx[6:0], mosi_spi};
            slv_bit++;
            if (slv_bit == 8) begin
                mosi_q.push_back(slv_rx);
                slv_bit = 0;
            end
        end else if (!sck_spi && prev_sck) begin
            if (slv_bit == 0) begin
                slv_byte++;
                slv_tx = (slv_byte - 1 < slv_q.size()) ? slv_q[slv_byte-1] : 8'h3C;
            end else begin
                slv_tx = {slv_tx[6:0], 1'b0};
            end
            miso_spi = slv_tx[7];
        end
        prev_ncs = (ncs_spi === 1'b1) || (ncs_spi === 1'bx);
        prev_sck = (sck_spi === 1'b1);
    end

    logic [7:0] rd_q[$];
    logic [7:0] exp_mosi_q[$];
    logic [7:0] exp_rd_q[$];
    int g_first_rise, g_rises, g_ncs_hi, g_ready, g_ncs_bad, g_busy_bad, g_last_pos, g_last_cnt;

    // Issue one command at cycle 0 and record the frame until cmd_ready returns.
    task automatic run_frame(input logic rd, input logic [7:0] op, input logic [31:0] wd,
                             input logic [LEN_W-1:0] ln);
        logic psck;
        mosi_q.delete(); rd_q.delete();
        g_first_rise = -1; g_rises = 0; g_ncs_hi = -1; g_ready = -1;
        g_ncs_bad = 0; g_busy_bad = 0; g_last_pos = -1; g_last_cnt = 0;
        bus.cmd_read = rd; bus.cmd_opcode = op; bus.cmd_wdata = wd; bus.cmd_len = ln;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        psck = 1'b0;
        for (int c = 1; c <= 3000 && g_ready < 0; c++) begin
            @(negedge clk);
            if (sck_spi && !psck) begin
                g_rises++;
                if (g_first_rise < 0) g_first_rise = c;
            end
            psck = sck_spi;
            if (bus.rd_valid) begin
                if (bus.rd_last) begin g_last_pos = rd_q.size(); g_last_cnt++; end
                rd_q.push_back(bus.rd_data);
            end
            if (ncs_spi && g_ncs_hi < 0) g_ncs_hi = c;
            if (!ncs_spi && g_ncs_hi >= 0) g_ncs_bad++;
            if (bus.cmd_ready) g_ready = c;
            else if (!busy) g_busy_bad++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_frame(input string tag, input int n_bits);
        int n_rd;
        chk({tag, " first_sck_rise"}, g_first_rise, 1 + D);
        chk({tag, " sck_rises"}, g_rises, n_bits);
        chk({tag, " ncs_high_cycle"}, g_ncs_hi, 1 + 2*n_bits*D + D);
        chk({tag, " cmd_ready_cycle"}, g_ready, 1 + 2*n_bits*D + 2*D);
        chk({tag, " ncs_relow"}, g_ncs_bad, 0);
        chk({tag, " busy_low_in_frame"}, g_busy_bad, 0);
        chk({tag, " mosi_bytes"}, mosi_q.size(), exp_mosi_q.size());
        for (int i = 0; i < exp_mosi_q.size() && i < mosi_q.size(); i++)
            chk($sformatf("%s mosi[%0d]", tag, i), mosi_q[i], exp_mosi_q[i]);
        n_rd = exp_rd_q.size();
        chk({tag, " rd_count"}, rd_q.size(), n_rd);
        for (int i = 0; i < n_rd && i < rd_q.size(); i++)
            chk($sformatf("%s rd[%0d]", tag, i), rd_q[i], exp_rd_q[i]);
        chk({tag, " rd_last_count"}, g_last_cnt, (n_rd > 0) ? 1 : 0);
        chk({tag, " rd_last_pos"}, g_last_pos, (n_rd > 0) ? n_rd - 1 : -1);
    endtask

    typedef struct {
        logic        rd;
        logic [7:0]  op;
        logic [31:0] wd;
        int          len;
        logic [31:0] sdata;
        int          exp_nbytes;
        logic [39:0] exp_mosi;
        int          exp_nrd;
        logic [23:0] exp_rd;
    } vec_t;

    vec_t tbl[5];

    task automatic table_frames();
        for (int v = 0; v < 5; v++) begin
            slv_q.delete(); exp_mosi_q.delete(); exp_rd_q.delete();
            for (int b = 3; b >= 0; b--) slv_q.push_back(tbl[v].sdata[8*b +: 8]);
            for (int b = 0; b < tbl[v].exp_nbytes && b < 5; b++)
                exp_mosi_q.push_back(tbl[v].exp_mosi[8*(4-b) +: 8]);
            for (int b = 0; b < tbl[v].exp_nrd; b++)
                exp_rd_q.push_back(tbl[v].exp_rd[8*(tbl[v].exp_nrd-1-b) +: 8]);
            run_frame(tbl[v].rd, tbl[v].op, tbl[v].wd, LEN_W'(tbl[v].len));
            check_frame($sformatf("vec%0d", v), 8 * tbl[v].exp_nbytes);
        end
    endtask

    task automatic random_frames();
        logic        r;
        logic [7:0]  op;
        logic [31:0] wd;
        int          ln, nb;
        for (int it = 0; it < 12; it++) begin
            r = 1'($urandom_range(0, 1));
            op = 8'($urandom);
            wd = $urandom;
            ln = $urandom_range(0, 5);
            slv_q.delete(); exp_mosi_q.delete(); exp_rd_q.delete();
            for (int b = 0; b < 6; b++) slv_q.push_back(8'($urandom));
            nb = r ? 1 + ln : 5;
            exp_mosi_q.push_back(op);
            for (int b = 1; b < nb; b++) exp_mosi_q.push_back(r ? 8'h00 : wd[8*(4-b) +: 8]);
            if (r) for (int b = 0; b < ln; b++) exp_rd_q.push_back(slv_q[b]);
            run_frame(r, op, wd, LEN_W'(ln));
            check_frame($sformatf("rand%0d", it), 8 * nb);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic hold_valid_seq();
        int r_cyc = -1;
        int base;
        base = ncs_fall_cnt;
        slv_q.delete();
        bus.cmd_read = 1'b1; bus.cmd_opcode = 8'h9F; bus.cmd_len = '0; bus.cmd_wdata = '0;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 500 && r_cyc < 0; c++) begin
            @(negedge clk);
            if (bus.cmd_ready) r_cyc = c;
            @(posedge clk); #1;
        end
        chk("hold first_ready_cycle", r_cyc, 1 + 16*D + 2*D);
        @(negedge clk);
        chk("hold second_frame_ncs", ncs_spi, 0);
        chk("hold second_frame_busy", busy, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 500 && !bus.cmd_ready; c++) begin @(posedge clk); #1; end
        repeat (20) begin @(posedge clk); #1; end
        chk("hold frame_count", ncs_fall_cnt - base, 2);
        chk("hold idle_ncs", ncs_spi, 1);
    endtask

    task automatic reset_mid_frame_seq();
        int rdv = 0;
        slv_q.delete();
        slv_q.push_back(8'h5A); slv_q.push_back(8'hC3); slv_q.push_back(8'hFF);
        bus.cmd_read = 1'b1; bus.cmd_opcode = 8'h80; bus.cmd_len = LEN_W'(3);
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (bus.rd_valid) rdv++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid ncs", ncs_spi, 1);
        chk("rst_mid sck", sck_spi, 0);
        chk("rst_mid cmd_ready", bus.cmd_ready, 1);
        chk("rst_mid busy", busy, 0);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.rd_valid) rdv++;
        end
        chk("rst_mid rd_valid_count", rdv, 0);
        @(posedge clk); #1;
    endtask

    task automatic trigger_sync_seq();
        for (int c = 0; c <= 60; c++) begin
            trig_req = (c == 10 || c == 20);
            ready_mcu = (c >= 50);
            @(negedge clk);
            chk($sformatf("trig@%0d", c), trigger_mcu, (c >= 11 && c <= 36) ? 1 : 0);
            chk($sformatf("avail@%0d", c), data_avail, (c >= 52) ? 1 : 0);
            chk($sformatf("rise@%0d", c), data_avail_rise, (c == 53) ? 1 : 0);
            @(posedge clk); #1;
        end
        trig_req = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        trig_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_vs_trig trigger_mcu", trigger_mcu, 0);
        chk("rst_vs_trig data_avail", data_avail, 0);
        ready_mcu = 1'b0;
        repeat (25) begin @(posedge clk); #1; end
    endtask

    // Model: trigger high for TRIG cycles after the latest request; flag delayed 2, edge 3.
    task automatic random_trig_sync();
        int   rdy[300];
        int   last_t = -1000;
        int   r2, r3, r4;
        logic cur_r = 1'b0;
        logic tq;
        for (int c = 0; c < 300; c++) begin
            tq = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) cur_r = ~cur_r;
            rdy[c] = cur_r ? 1 : 0;
            trig_req = tq;
            ready_mcu = cur_r;
            @(negedge clk);
            r2 = (c >= 2) ? rdy[c-2] : 0;
            r3 = (c >= 3) ? rdy[c-3] : 0;
            r4 = (c >= 4) ? rdy[c-4] : 0;
            chk($sformatf("rtrig@%0d", c), trigger_mcu, (c - last_t >= 1 && c - last_t <= TRIG) ? 1 : 0);
            chk($sformatf("ravail@%0d", c), data_avail, r2);
            chk($sformatf("rrise@%0d", c), data_avail_rise, (r3 == 1 && r4 == 0) ? 1 : 0);
            if (tq) last_t = c;
            @(posedge clk); #1;
        end
        trig_req = 1'b0;
        ready_mcu = 1'b0;
        repeat (25) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 8'h01, 32'h00ABCDEF, 0, 32'h77777777, 5, 40'h0100ABCDEF, 0, 24'h0};
        tbl[1] = '{1'b1, 8'h80, 32'hDEADBEEF, 3, 32'h5AC3FF00, 4, 40'h8000000000, 3, 24'h5AC3FF};
        tbl[2] = '{1'b1, 8'h9F, 32'h00000000, 0, 32'h11223344, 1, 40'h9F00000000, 0, 24'h0};
        tbl[3] = '{1'b0, 8'hFF, 32'hFFFFFFFF, 0, 32'h00000000, 5, 40'hFFFFFFFFFF, 0, 24'h0};
        tbl[4] = '{1'b1, 8'h3C, 32'h12345678, 1, 32'h81000000, 2, 40'h3C00000000, 1, 24'h000081};

        miso_spi = 1'b0;
        rst = 1'b1; trig_req = 1'b0; ready_mcu = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_opcode = '0;
        bus.cmd_wdata = '0; bus.cmd_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset cmd_ready", bus.cmd_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset ncs", ncs_spi, 1);
        chk("reset sck", sck_spi, 0);
        chk("reset mosi", mosi_spi, 0);
        chk("reset rd_valid", bus.rd_valid, 0);
        chk("reset rd_last", bus.rd_last, 0);
        chk("reset rd_data", bus.rd_data, 0);
        chk("reset trigger", trigger_mcu, 0);
        chk("reset data_avail", data_avail, 0);
        chk("reset data_avail_rise", data_avail_rise, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        table_frames();
        hold_valid_seq();
        reset_mid_frame_seq();
        random_frames();
        trigger_sync_seq();
        random_trig_sync();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dso_spi_host.md
# dso_spi_host

SPI master for the DSO board's MCU link: the initiator end of the interface whose responder is the board-side SPI slave. Used as the host side in system benches, and as the bridge when a second FPGA drives the DSO board instead of the MCU. Converts single commands (config-register write, buffer read) into SPI mode-0 frames. Also drives the `trigger_mcu` request and synchronises the `ready_mcu` data-available flag.

## Interface
Parameters:
- CLK_DIV, 4: SCK half-period in `clk` cycles; ≥1.
- LEN_W, 12: width of the read byte count.
- TRIG_CYCLES, 16: `trigger_mcu` pulse length in `clk` cycles; ≥1.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  host idle and able to accept a command.
- cmd_read  in  1  1 = read frame, 0 = write frame.
- cmd_opcode  in  8  first byte shifted out in every frame.
- cmd_wdata  in  32  write payload, sent MSB byte first.
- cmd_len  in  LEN_W  number of read bytes (read frames only).
- rd_valid  out  1  one-cycle strobe: rd_data is valid.
- rd_data  out  8  received byte, MSB = first bit received.
- rd_last  out  1  qualifies rd_valid on the final byte of the frame.
- busy  out  1  frame in progress (includes lead, lag and gap).
- sck_spi  out  1  SPI clock, idles low.
- mosi_spi  out  1  SPI data out.
- ncs_spi  out  1  chip select, active-low.
- miso_spi  in  1  SPI data in.
- trig_req  in  1  request a trigger pulse to the board.
- trigger_mcu  out  1  trigger line to the board.
- ready_mcu  in  1  board data-available flag; asynchronous input.
- data_avail  out  1  ready_mcu after a 2-flop synchroniser.
- data_avail_rise  out  1  one-cycle pulse on each rising edge of data_avail.

## Operation
- Reset values: cmd_ready=1, busy=0, ncs_spi=1, sck_spi=0, mosi_spi=0, rd_valid=0, rd_last=0, rd_data=0, trigger_mcu=0, data_avail=0, data_avail_rise=0, synchroniser flops=0.
- State machine:
  - IDLE → LEAD on `cmd_valid & cmd_ready`; the command is latched on that cycle.
  - LEAD → SHIFT after D=CLK_DIV cycles.
  - SHIFT → LAG after the last falling SCK edge.
  - LAG → GAP after D cycles.
  - GAP → IDLE after D cycles.
- Frame length B in bytes:
  - Write frame: B=5 (opcode, then cmd_wdata[31:24] … [7:0]).
  - Read frame: B=1+cmd_len; MOSI=0 during read bytes.
  - Read with cmd_len=0: opcode only, no rd_valid.
- Bit order is MSB first. Mode 0: MOSI is updated on falling edges (first bit at ncs fall); MISO is sampled on rising edges.
- Bits received during the opcode byte and during write payload bytes are discarded.
- Byte counter is LEN_W+1 bits wide. Bit counter wraps 7→0 per byte.
- Trigger:
  - trig_req=1 loads a counter with TRIG_CYCLES; trigger_mcu=1 while the counter is non-zero.
  - trig_req while the pulse is active reloads the counter (retrigger).
  - Trigger logic is independent of the frame FSM.
- ready_mcu is synchronised only; it does not gate commands.

## Timing
- Command accepted at cycle 0. From cycle 1: ncs_spi=0, busy=1, cmd_ready=0, MOSI = bit 7 of the opcode.
- With N=8B bits: bit k (0-based) rising edge at cycle 1+(2k+1)D, falling edge at 1+(2k+2)D. Last falling edge at 1+2ND.
- ncs_spi=1 at 1+2ND+D. cmd_ready=1 and busy=0 at 1+2ND+2D.
- rd_valid pulses the cycle after the rising edge that samples a read byte's bit 0. rd_last is set with the final rd_valid. No backpressure.
- cmd_valid while cmd_ready=0 is ignored and not queued.
- data_avail lags ready_mcu by 2 cycles; data_avail_rise lags by 3.
- trig_req at cycle t: trigger_mcu=1 over cycles t+1 … t+TRIG_CYCLES.
- rst asserted mid-frame: on the next cycle, reset values apply. The partial frame is dropped with no further rd_valid.
- trig_req and rst in the same cycle: rst wins.

## Test plan
- Reset, then write with CLK_DIV=4, opcode=0x01, wdata=0x00ABCDEF:
  - MOSI bytes 01 00 AB CD EF.
  - ncs_spi low over cycles 1–324, high at 325; cmd_ready=1 at 329.
  - 40 SCK rising edges, the first at cycle 5.
- Read with opcode=0x80, cmd_len=3, slave model returns 5A C3 FF: three rd_valid strobes carrying 5A, C3, FF, with rd_last only on FF; MOSI=0 after the opcode.
- Read with cmd_len=0: 8 SCK pulses, no rd_valid; cmd_ready returns at cycle 1+16D+2D.
- cmd_valid held high throughout a frame: exactly one frame, then a second starts one cycle after cmd_ready returns.
- rst asserted at cycle 100 of a read: ncs_spi=1, sck_spi=0, cmd_ready=1 at cycle 101; no rd_valid afterwards.
- trig_req at cycle 10 and again at 20 with TRIG_CYCLES=16: trigger_mcu high over cycles 11–36. ready_mcu rising at cycle 50: data_avail=1 at 52, data_avail_rise pulse at 53.
